medidor_frecuencia: RTL

Measures the frequency of a slow, asynchronous input signal by counting its rising edges over a fixed gate window of system-clock cycles. It is the receiving end of the divided clocks our dividers generate. It synchronizes the input, detects edges and counts them per window. At each window end it publishes the count with a one-cycle valid strobe. Used in the vending-machine lab to check divider outputs and to read external pulse sources.

---
 rtl/medidor_frecuencia.sv | 123 ++++++++++++
 1 files changed

// File: rtl/medidor_frecuencia.sv
// Frequency meter: counts synchronized rising edges of senal over a gate window
// of GATE_CYCLES reloje cycles and publishes the count with a one-cycle strobe.
module medidor_frecuencia #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int          CNT_W       = 32
) (
  input  logic             reloje,
  input  logic             reset,
  input  logic             senal,
  input  logic             habilitar,
  output logic [CNT_W-1:0] frecuencia,
  output logic             valido,
  output logic             desborde
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    FIN  = 2'd2
  } estado_t;

  // Last GATE cycle carries g == GATE_CYCLES-2; the FIN cycle completes the window.
  localparam logic [31:0] G_PEN = 32'(GATE_CYCLES - 32'd2);

  estado_t          estado_r, estado_s;
  logic             s1_r, s2_r, s3_r;
  logic [31:0]      g_r, g_s;
  logic [CNT_W-1:0] c_r, c_s, c_inc_s;
  logic             sat_r, sat_s;
  logic             edge_s, lleno_s, ovf_s, carga_s;

  assign edge_s  = s2_r & ~s3_r;
  assign lleno_s = &c_r;
  assign ovf_s   = edge_s & lleno_s;
  assign c_inc_s = (edge_s && !lleno_s) ? (c_r + CNT_W'(1)) : c_r;

  // Synchronizer and edge-history flops for the asynchronous input.
  always_ff @(posedge reloje or posedge reset) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= senal;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // State, gate counter, edge counter and saturation flag.
  always_ff @(posedge reloje or posedge reset) begin
    if (reset) begin
      estado_r <= IDLE;
      g_r      <= 32'd0;
      c_r      <= '0;
      sat_r    <= 1'b0;
    end else begin
      estado_r <= estado_s;
      g_r      <= g_s;
      c_r      <= c_s;
      sat_r    <= sat_s;
    end
  end

  // Next-state and datapath; the FIN cycle still counts its own edge.
  always_comb begin
    estado_s = estado_r;
    g_s      = 32'd0;
    c_s      = '0;
    sat_s    = 1'b0;
    carga_s  = 1'b0;
    case (estado_r)
      IDLE: begin
        if (habilitar) begin
          estado_s = GATE;
        end else begin
          estado_s = IDLE;
        end
      end
      GATE: begin
        if (!habilitar) begin
          estado_s = IDLE;
        end else begin
          g_s   = g_r + 32'd1;
          c_s   = c_inc_s;
          sat_s = sat_r | ovf_s;
          if (g_r == G_PEN) begin
            estado_s = FIN;
          end else begin
            estado_s = GATE;
          end
        end
      end
      FIN: begin
        carga_s = 1'b1;
        if (habilitar) begin
          estado_s = GATE;
        end else begin
          estado_s = IDLE;
        end
      end
      default: begin
        estado_s = IDLE;
      end
    endcase
  end

  // Published result; frecuencia and desborde hold across aborted windows.
  always_ff @(posedge reloje or posedge reset) begin
    if (reset) begin
      frecuencia <= '0;
      valido     <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      valido <= carga_s;
      if (carga_s) begin
        frecuencia <= c_inc_s;
        desborde   <= sat_r | ovf_s;
      end
    end
  end

endmodule
